lc3_regfile_cc: RTL
===================

# lc3_regfile_cc

LC-3 general-purpose register file (R0–R7) with the condition-code (NZP) register and branch-enable (BEN) register. It sits directly upstream of the registered source-operand read stage: it accepts writeback from the datapath bus and drives all eight register values plus two combinational source-operand ports. NZP and BEN are updated from the same bus under control-FSM load strobes.

## Interface
- N, 16, data width of each register and of the bus
- Clk  in  1  system clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high; clock Clk
- LD_REG  in  1  write Bus into R[DR] at next edge
- DR  in  3  destination register index
- SR1  in  3  source-operand-1 index
- SR2  in  3  source-operand-2 index
- Bus  in  N  datapath bus; writeback and CC source
- LD_CC  in  1  update NZP from Bus at next edge
- LD_BEN  in  1  update BEN at next edge
- IR_11_9  in  3  branch condition mask n,z,p from instruction
- R0_Out … R7_Out  out  N each  current register contents
- SR1_Out  out  N  R[SR1], combinational read
- SR2_Out  out  N  R[SR2], combinational read
- NZP  out  3  condition codes {N,Z,P}
- BEN  out  1  branch enable

## Operation
- Reset (priority over all loads): R0–R7 = 16'h0000, NZP = 3'b010, BEN = 0.
- Write: LD_REG=1 → R[DR] <= Bus at edge; other registers hold. One write port only.
- Reads: SR1_Out/SR2_Out are pure index muxes of current state; SR1==SR2 legal, both return the same value.
- Read-during-write: no bypass. In the write cycle, reads of R[DR] return the old value; new value visible after the edge.
- CC generation (signed): Bus[N-1]=1 → 3'b100; Bus==0 → 3'b010; else 3'b001. Exactly one bit set after any LD_CC.
- LD_CC=1 → NZP <= generated code; LD_CC=0 → hold.
- LD_BEN=1 → BEN <= |(IR_11_9 & NZP), using NZP *before* the edge. LD_BEN=0 → hold.
- Simultaneous LD_REG & LD_CC: both use the same Bus value in the same edge.
- Simultaneous LD_CC & LD_BEN: BEN sees old NZP; new NZP affects BEN only on a later LD_BEN.
- Reset asserted mid-sequence: all state cleared at that edge regardless of strobes; loads resume the cycle after Reset deasserts.
- IR_11_9 = 3'b000 → BEN <= 0; 3'b111 → BEN <= 1 (NZP always one-hot after reset or LD_CC).

## Timing
- Write latency: 1 edge from LD_REG to R*_Out/SRx_Out update.
- Read latency: 0 cycles (combinational from state and SR1/SR2).
- NZP, BEN: 1 edge after strobe.
- All outputs are register outputs or muxes of registers; no input-to-output combinational path except SR1/SR2 → SRx_Out.
- Strobes are level-sensitive per cycle; holding a strobe high for k cycles performs k loads.

## Structure
- Shared package lc3_pkg: reg_idx_t (3-bit), nzp_t (3-bit), constants NZP_N=3'b100, NZP_Z=3'b010, NZP_P=3'b001, NZP_RESET=NZP_Z.
- Register array: 8 instances of the team's N-bit load-enable register with per-register load = LD_REG & (DR==i).
- One natural sub-module: nzp_gen (combinational Bus → nzp_t), reused by any later CC-setting stage.
- BEN and NZP as local always_ff with Reset priority.

## Test plan
- Reset then read all: assert Reset 1 cycle → R0–R7=16'h0000, SR1_Out=SR2_Out=0, NZP=3'b010, BEN=0.
- Write/readback: LD_REG=1, DR=3, Bus=16'hBEEF → same cycle SR1=3 reads 16'h0000; next cycle R3_Out=SR1_Out=16'hBEEF, other registers 0.
- CC coding: LD_CC with Bus=16'h8000 → NZP=100; Bus=16'h0000 → 010; Bus=16'h7FFF → 001.
- BEN ordering: NZP=010, same cycle LD_CC (Bus=16'h0001) and LD_BEN with IR_11_9=3'b010 → BEN=1, NZP=001; next LD_BEN with IR_11_9=3'b010 → BEN=0.
- Full sweep: write R[i]=16'h1111*i for i=0..7 back-to-back, then read all pairs (SR1,SR2) → every port returns programmed value; SR1=SR2=7 → both 16'h7777.
- Reset mid-op: Reset and LD_REG (DR=5, Bus=16'h1234) and LD_CC (Bus negative) in the same cycle → R5=0, NZP=010; loads apply normally next cycle.

Source files
------------

// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared LC-3 types and condition-code constants
package lc3_pkg;

  typedef logic [2:0] reg_idx_t;
  typedef logic [2:0] nzp_t;

  localparam nzp_t NZP_N     = 3'b100;
  localparam nzp_t NZP_Z     = 3'b010;
  localparam nzp_t NZP_P     = 3'b001;
  localparam nzp_t NZP_RESET = NZP_Z;

endpackage

// File: rtl/lc3_ld_reg.sv
// rtl/lc3_ld_reg.sv - N-bit load-enable register with synchronous active-high reset
module lc3_ld_reg #(
  parameter int N = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         i_ld,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_q
);

  logic [N-1:0] r_q;

  always_ff @(posedge Clk) begin
    if (Reset)
      r_q <= '0;
    else if (i_ld)
      r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/lc3_regfile_cc_nzp_gen.sv
// rtl/lc3_regfile_cc_nzp_gen.sv - combinational signed condition-code generator
module nzp_gen
  import lc3_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0] i_bus,
  output nzp_t         o_nzp
);

  always_comb begin
    o_nzp = NZP_P;
    if (i_bus[N-1])
      o_nzp = NZP_N;
    else if (i_bus == '0)
      o_nzp = NZP_Z;
  end

endmodule

// File: rtl/lc3_regfile_cc.sv
// rtl/lc3_regfile_cc.sv - LC-3 R0-R7 register file with NZP and BEN registers
module lc3_regfile_cc
  import lc3_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         LD_REG,
  input  logic [2:0]   DR,
  input  logic [2:0]   SR1,
  input  logic [2:0]   SR2,
  input  logic [N-1:0] Bus,
  input  logic         LD_CC,
  input  logic         LD_BEN,
  input  logic [2:0]   IR_11_9,
  output logic [N-1:0] R0_Out,
  output logic [N-1:0] R1_Out,
  output logic [N-1:0] R2_Out,
  output logic [N-1:0] R3_Out,
  output logic [N-1:0] R4_Out,
  output logic [N-1:0] R5_Out,
  output logic [N-1:0] R6_Out,
  output logic [N-1:0] R7_Out,
  output logic [N-1:0] SR1_Out,
  output logic [N-1:0] SR2_Out,
  output logic [2:0]   NZP,
  output logic         BEN
);

  logic [N-1:0] w_regs [8];
  nzp_t         w_nzp_next;
  nzp_t         r_nzp;
  logic         r_ben;

  for (genvar i = 0; i < 8; i++) begin : g_reg
    lc3_ld_reg #(.N(N)) u_reg (
      .Clk   (Clk),
      .Reset (Reset),
      .i_ld  (LD_REG && (reg_idx_t'(DR) == reg_idx_t'(i))),
      .i_d   (Bus),
      .o_q   (w_regs[i])
    );
  end

  nzp_gen #(.N(N)) u_nzp_gen (
    .i_bus (Bus),
    .o_nzp (w_nzp_next)
  );

  // BEN samples r_nzp before this edge's LD_CC takes effect
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_nzp <= NZP_RESET;
      r_ben <= 1'b0;
    end else begin
      if (LD_CC)
        r_nzp <= w_nzp_next;
      if (LD_BEN)
        r_ben <= |(IR_11_9 & r_nzp);
    end
  end

  assign R0_Out  = w_regs[0];
  assign R1_Out  = w_regs[1];
  assign R2_Out  = w_regs[2];
  assign R3_Out  = w_regs[3];
  assign R4_Out  = w_regs[4];
  assign R5_Out  = w_regs[5];
  assign R6_Out  = w_regs[6];
  assign R7_Out  = w_regs[7];
  assign SR1_Out = w_regs[SR1];
  assign SR2_Out = w_regs[SR2];
  assign NZP     = r_nzp;
  assign BEN     = r_ben;

endmodule
